inst_rom_loader: RTL

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/inst_rom_loader.sv
// Boot-image loader: assembles a big-endian byte stream into 32-bit words and
// holds the CPU core in reset until the image is complete.
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  rom_chip_enable,
  input  logic [31:0]           rom_addr,
  output logic [31:0]           rom_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   loaded_words
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_WORD   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  // Address bits above the word index; any of them set means out of range.
  localparam logic [31:0] HI_MASK = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [1:0]              byte_cnt;
  logic [31:0]             asm_word;
  logic [31:0]             storage [DEPTH];

  logic                    accept;
  logic                    full;
  logic                    commit;
  logic [31:0]             word_next;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    rd_hit;

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  pos,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (pos)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  // asm_word is cleared after every commit, so bytes not yet received read
  // as zero and a short final word is padded for free.
  always_comb begin
    accept    = load_valid && (state == S_LOAD);
    full      = (loaded_words == FULL_COUNT);
    word_next = insert_byte(asm_word, byte_cnt, load_byte);
    commit    = accept && !full && (load_last || (byte_cnt == 2'd3));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_LOAD;
      byte_cnt     <= 2'd0;
      asm_word     <= 32'd0;
      loaded_words <= '0;
      load_error   <= 1'b0;
      cpu_reset    <= 1'b1;
    end else begin
      cpu_reset <= (state == S_LOAD);
      if (accept) begin
        if (full) begin
          load_error <= 1'b1;
        end else if (commit) begin
          loaded_words <= loaded_words + ONE_WORD;
          byte_cnt     <= 2'd0;
          asm_word     <= 32'd0;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_word <= word_next;
        end
        if (load_last) state <= S_RUN;
      end
    end
  end

  // Storage is never cleared; the read mask below hides stale words.
  always_ff @(posedge clock) begin
    if (commit && !reset) storage[loaded_words[ADDR_WIDTH-1:0]] <= word_next;
  end

  always_comb begin
    rd_idx   = rom_addr[ADDR_WIDTH+1:2];
    rd_hit   = rom_chip_enable && (state == S_RUN) && ((rom_addr & HI_MASK) == 32'd0)
               && ({1'b0, rd_idx} < loaded_words);
    rom_data = rd_hit ? storage[rd_idx] : 32'd0;
  end

  assign load_ready = (state == S_LOAD);
  assign load_done  = (state == S_RUN);

endmodule
